// File: rtl/squeezer1088_pkg.sv
// Shared Keccak squeeze-side constants and FSM encodings, common to the
// padder, the permutation wrapper and the squeezer.
package squeezer1088_pkg;

  localparam int RATE_BITS  = 1088;
  localparam int WORD_BITS  = 32;
  localparam int RATE_WORDS = RATE_BITS / WORD_BITS;
  localparam int CNT_BITS   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WAIT  = 2'd2
  } sqz_state_t;

endpackage

// File: rtl/squeezer1088.sv
// Squeeze stage: captures one rate block from the permutation and drains it
// MSB-word first, requesting another permutation when the block is used up.
module squeezer1088 #(
  parameter int RATE_BITS = squeezer1088_pkg::RATE_BITS,
  parameter int WORD_BITS = squeezer1088_pkg::WORD_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RATE_BITS-1:0] in,
  input  logic                 in_ready,
  input  logic                 out_ack,
  input  logic                 stop,
  output logic [WORD_BITS-1:0] out,
  output logic                 out_valid,
  output logic                 perm_req,
  output logic                 done,
  output logic                 overrun
);
  import squeezer1088_pkg::*;

  localparam int WORDS    = RATE_BITS / WORD_BITS;
  localparam int LAST_IDX = WORDS - 1;

  sqz_state_t           state_r;
  sqz_state_t           state_nx_s;
  logic [RATE_BITS-1:0] data_r;
  logic [CNT_BITS-1:0]  cnt_r;
  logic                 perm_req_r;
  logic                 done_r;
  logic                 overrun_r;

  logic                 capture_s;
  logic                 shift_s;
  logic                 discard_s;
  logic                 perm_req_nx_s;
  logic                 done_nx_s;
  logic                 overrun_set_s;
  logic                 last_word_s;

  assign last_word_s = (cnt_r == CNT_BITS'(LAST_IDX));

  // Next-state decode; stop wins over the end-of-block transition.
  always_comb begin
    state_nx_s    = state_r;
    capture_s     = 1'b0;
    shift_s       = 1'b0;
    discard_s     = 1'b0;
    perm_req_nx_s = 1'b0;
    done_nx_s     = 1'b0;
    overrun_set_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_WAIT: begin
        if (in_ready) begin
          capture_s  = 1'b1;
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_DRAIN: begin
        overrun_set_s = in_ready;
        if (out_ack) begin
          if (stop) begin
            discard_s  = 1'b1;
            done_nx_s  = 1'b1;
            state_nx_s = ST_IDLE;
          end else if (last_word_s) begin
            perm_req_nx_s = 1'b1;
            state_nx_s    = ST_WAIT;
          end else begin
            shift_s = 1'b1;
          end
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, buffer, counter and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      data_r     <= {RATE_BITS{1'b0}};
      cnt_r      <= {CNT_BITS{1'b0}};
      perm_req_r <= 1'b0;
      done_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      perm_req_r <= perm_req_nx_s;
      done_r     <= done_nx_s;
      if (capture_s) begin
        data_r <= in;
        cnt_r  <= {CNT_BITS{1'b0}};
      end else if (shift_s) begin
        data_r <= {data_r[RATE_BITS-WORD_BITS-1:0], {WORD_BITS{1'b0}}};
        cnt_r  <= cnt_r + CNT_BITS'(1);
      end else if (discard_s) begin
        data_r <= {RATE_BITS{1'b0}};
      end
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign out       = data_r[RATE_BITS-1 -: WORD_BITS];
  assign out_valid = (state_r == ST_DRAIN);
  assign perm_req  = perm_req_r;
  assign done      = done_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_squeezer1088.sv
// Directed/randomized bench for squeezer1088 against a queue-based model of
// the squeeze word stream.
module tb_squeezer1088;

  logic          clk;
  logic          reset;
  logic [1087:0] in;
  logic          in_ready;
  logic          out_ack;
  logic          stop;
  logic [31:0]   out;
  logic          out_valid;
  logic          perm_req;
  logic          done;
  logic          overrun;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_q[$];
  bit          m_active  = 1'b0;
  bit          m_perm    = 1'b0;
  bit          m_done    = 1'b0;
  bit          m_overrun = 1'b0;

  squeezer1088 dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_ready (in_ready),
    .out_ack  (out_ack),
    .stop     (stop),
    .out      (out),
    .out_valid(out_valid),
    .perm_req (perm_req),
    .done     (done),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: a block becomes a queue of 34 words, MSB word first.
  task automatic model_step();
    m_perm = 1'b0;
    m_done = 1'b0;
    if (reset) begin
      m_q.delete();
      m_active  = 1'b0;
      m_overrun = 1'b0;
    end else if (m_active) begin
      if (in_ready) m_overrun = 1'b1;
      if (out_ack) begin
        void'(m_q.pop_front());
        if (stop) begin
          m_q.delete();
          m_active = 1'b0;
          m_done   = 1'b1;
        end else if (m_q.size() == 0) begin
          m_active = 1'b0;
          m_perm   = 1'b1;
        end
      end
    end else if (in_ready) begin
      m_q.delete();
      for (int k = 0; k < 34; k++) m_q.push_back(in[1087-32*k -: 32]);
      m_active = 1'b1;
    end
  endtask

  task automatic cyc(input logic r, input logic ir, input logic [1087:0] d,
                     input logic ack, input logic stp);
    reset = r; in_ready = ir; in = d; out_ack = ack; stop = stp;
    model_step();
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_active});
    if (m_active) chk("out_word", out, m_q[0]);
    if (r) chk("out_after_reset", out, 32'd0);
    chk("perm_req", {31'd0, perm_req}, {31'd0, m_perm});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("overrun", {31'd0, overrun}, {31'd0, m_overrun});
  endtask

  function automatic logic [1087:0] rand_block();
    logic [1087:0] b;
    for (int i = 0; i < 34; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  // Acknowledge n words; random gaps when rnd is set, bounded cycle budget.
  task automatic ack_words(input int n, input bit rnd);
    int   acked = 0;
    int   guard = 0;
    logic a;
    while (acked < n && guard < 500) begin
      a = rnd ? logic'($urandom_range(0, 1)) : 1'b1;
      cyc(1'b0, 1'b0, '0, a, 1'b0);
      if (a) acked++;
      guard++;
    end
    checks++;
    if (acked < n) begin
      errors++;
      $error("FAIL ack_budget observed=%0d expected=%0d", acked, n);
    end
  endtask

  logic [1087:0] blk;
  logic [31:0]   held;

  initial begin
    reset = 1'b1; in_ready = 1'b0; in = '0; out_ack = 1'b0; stop = 1'b0;
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, {34{32'hFFFFFFFF}}, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Capture + full drain
    blk = rand_block();
    blk[1087:1056] = 32'hDEADBEEF;
    blk[31:0]      = 32'h01234567;
    cyc(1'b0, 1'b1, blk, 1'b0, 1'b0);
    chk("first_word", out, 32'hDEADBEEF);
    ack_words(33, 1'b0);
    chk("last_word", out, 32'h01234567);
    ack_words(1, 1'b0);
    chk("perm_req_after_34", {31'd0, perm_req}, 32'd1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("wait_perm_pulse_once", {31'd0, perm_req}, 32'd0);

    // Backpressure on word 3
    cyc(1'b0, 1'b1, rand_block(), 1'b0, 1'b0);
    ack_words(3, 1'b0);
    held = out;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("bp_hold", out, held);
    ack_words(31, 1'b1);

    // Early stop on word 7, then restart at word 0
    blk = rand_block();
    cyc(1'b0, 1'b1, blk, 1'b0, 1'b0);
    ack_words(7, 1'b1);
    chk("word7", out, blk[1087-32*7 -: 32]);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("stop_done", {31'd0, done}, 32'd1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    blk = rand_block();
    cyc(1'b0, 1'b1, blk, 1'b0, 1'b0);
    chk("restart_word0", out, blk[1087:1056]);

    // Stop on word 33 beats end-of-block
    ack_words(33, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("stop33_no_perm", {31'd0, perm_req}, 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Multi-block squeeze
    cyc(1'b0, 1'b1, {34{32'hA5A5A5A5}}, 1'b0, 1'b0);
    ack_words(34, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, {34{32'h5A5A5A5A}}, 1'b0, 1'b0);
    chk("block2_word0", out, 32'h5A5A5A5A);
    ack_words(34, 1'b1);
    chk("multi_no_overrun", {31'd0, overrun}, 32'd0);

    // Overrun during word 10 and on the final ack
    blk = rand_block();
    cyc(1'b0, 1'b1, blk, 1'b0, 1'b0);
    ack_words(10, 1'b0);
    cyc(1'b0, 1'b1, rand_block(), 1'b0, 1'b0);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    chk("overrun_data_kept", out, blk[1087-32*10 -: 32]);
    ack_words(23, 1'b1);
    cyc(1'b0, 1'b1, rand_block(), 1'b1, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Reset mid-drain at word 20
    cyc(1'b0, 1'b1, rand_block(), 1'b0, 1'b0);
    ack_words(20, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("rst_overrun_clr", {31'd0, overrun}, 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    blk = rand_block();
    cyc(1'b0, 1'b1, blk, 1'b0, 1'b0);
    chk("post_rst_word0", out, blk[1087:1056]);
    ack_words(34, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/squeezer1088.md
SQUEEZER1088 -- requirements
Module: squeezer1088

Interface
REQ-001 SHALL have parameter RATE_BITS, default 1088, meaning the Keccak rate in bits (SHA3-256/SHAKE256).
REQ-002 SHALL have parameter WORD_BITS, default 32, meaning the output word width; RATE_WORDS = RATE_BITS/WORD_BITS = 34.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in  input  1088  rate portion of the permutation state.
REQ-006 SHALL have port in_ready  input  1  `in` valid this cycle; one-cycle pulse from the permutation.
REQ-007 SHALL have port out_ack  input  1  consumer accepts the current `out` word this cycle.
REQ-008 SHALL have port stop  input  1  qualified by out_ack; no further words are wanted after the acked word.
REQ-009 SHALL have port out  output  32  current output word.
REQ-010 SHALL have port out_valid  output  1  `out` holds a valid word.
REQ-011 SHALL have port perm_req  output  1  one-cycle request for another permutation (next squeeze block).
REQ-012 SHALL have port done  output  1  one-cycle pulse when the squeeze is terminated by stop.
REQ-013 SHALL have port overrun  output  1  sticky flag: in_ready arrived while draining.

Function
REQ-014 SHALL implement FSM states IDLE, DRAIN and WAIT.
REQ-015 In IDLE or WAIT, in_ready=1 SHALL capture `in` into a 1088-bit buffer, clear the 6-bit word counter and enter DRAIN.
REQ-016 out_valid SHALL be 1 exactly in DRAIN; first word valid the cycle after in_ready (latency 1).
REQ-017 Word k (k=0..33) SHALL equal in[1087-32k -: 32]; the MSB word goes first, mirroring the padder's shift order.
REQ-018 In DRAIN, out_ack=1 SHALL shift the buffer left by 32 and increment the counter; out SHALL hold steady while out_ack=0.
REQ-019 out_ack with stop=1 in DRAIN (any k) SHALL enter IDLE, pulse done next cycle and discard the remaining words.
REQ-020 out_ack on word 33 with stop=0 SHALL enter WAIT and pulse perm_req for exactly one cycle next cycle.
REQ-021 stop SHALL take priority over the end-of-block transition on word 33.
REQ-022 in_ready in DRAIN, including the cycle of the final ack, SHALL be ignored for data and SHALL set overrun until reset.
REQ-023 out_ack or stop outside DRAIN SHALL be ignored.
REQ-024 The counter SHALL never exceed 33; no wrap-around occurs.

Reset
REQ-025 reset SHALL force state IDLE, counter 0, buffer 0, out=0, out_valid=0, perm_req=0, done=0, overrun=0.
REQ-026 reset SHALL take priority over all inputs; reset mid-DRAIN or mid-WAIT abandons the block without emitting perm_req or done.

Structure
REQ-027 A shared package SHALL hold RATE_BITS, WORD_BITS, RATE_WORDS and the FSM state encodings, shared with the padder and permutation wrapper.
REQ-028 The block SHALL be a single module with no sub-module: buffer shift register, counter and FSM inline.

Verification
REQ-029 Capture + full drain: in_ready with in[1087:1056]=32'hDEADBEEF and in[31:0]=32'h01234567, out_ack held high -> 34 words, first 32'hDEADBEEF, last 32'h01234567; perm_req pulses 1 cycle after the 34th ack; state WAIT.
REQ-030 Backpressure: out_ack low for 5 cycles on word 3 -> out stable and out_valid=1 throughout; word 4 appears the cycle after ack.
REQ-031 Early stop: stop=1 with ack of word 7 -> done pulse next cycle, out_valid=0, no perm_req; the next in_ready restarts at word 0.
REQ-032 Multi-block squeeze: two blocks with 32'hA5A5A5A5 pattern then 32'h5A5A5A5A -> 68 ordered words, one perm_req between blocks, overrun=0.
REQ-033 Overrun: in_ready during word 10 -> overrun=1 and stays 1; the output stream continues from the original buffer unchanged.
REQ-034 Reset mid-drain at word 20 -> next cycle all outputs 0 and state IDLE; the following in_ready yields word 0 of the new block.
